// File: rtl/switch_debounce.sv
// Multi-bit switch/button debouncer: I/O-stage capture, two-flop synchronizer,
// per-bit stability counter, plus registered edge pulses and toggle state.
module switch_debounce #(
  parameter int WIDTH          = 8,
  parameter int DEBOUNCE_COUNT = 1250000,
  parameter bit USEIOFF        = 1'b1
) (
  input  logic             clk_125mhz,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_n,
  output logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic [WIDTH-1:0] sw_toggle,
  output logic             any_change
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_COUNT - 1);

  logic [WIDTH-1:0] io_reg;
  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] lvl;
  logic [WIDTH-1:0] mismatch;
  logic [WIDTH-1:0] expire;

  logic [WIDTH-1:0] sw_reg;
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] fall_reg;
  logic [WIDTH-1:0] toggle_reg;

  // First capture stage: pad register or fabric register, kept through synthesis either way.
  generate
    if (USEIOFF) begin : g_ioff
      (* syn_useioff = 1, syn_preserve = 1 *) logic [WIDTH-1:0] io_stage_reg;
      always_ff @(posedge clk_125mhz) begin
        if (!rst_n) io_stage_reg <= '1;
        else        io_stage_reg <= sw_n;
      end
      assign io_reg = io_stage_reg;
    end else begin : g_fabric
      (* syn_useioff = 0, syn_preserve = 1 *) logic [WIDTH-1:0] io_stage_reg;
      always_ff @(posedge clk_125mhz) begin
        if (!rst_n) io_stage_reg <= '1;
        else        io_stage_reg <= sw_n;
      end
      assign io_reg = io_stage_reg;
    end
  endgenerate

  always_ff @(posedge clk_125mhz) begin
    if (!rst_n) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
    end else begin
      sync1_reg <= io_reg;
      sync2_reg <= sync1_reg;
    end
  end

  assign lvl = ~sync2_reg;

  // Each bit counts consecutive cycles of disagreement with the accepted level.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CNT_W-1:0] cnt_reg;

      assign mismatch[gi] = lvl[gi] ^ sw_reg[gi];
      assign expire[gi]   = mismatch[gi] && (cnt_reg == CNT_MAX);

      always_ff @(posedge clk_125mhz) begin
        if (!rst_n)                        cnt_reg <= '0;
        else if (!mismatch[gi] || expire[gi]) cnt_reg <= '0;
        else                               cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  endgenerate

  always_ff @(posedge clk_125mhz) begin
    if (!rst_n) begin
      sw_reg     <= '0;
      rise_reg   <= '0;
      fall_reg   <= '0;
      toggle_reg <= '0;
    end else begin
      sw_reg     <= sw_reg ^ expire;
      rise_reg   <= expire & lvl;
      fall_reg   <= expire & ~lvl;
      toggle_reg <= toggle_reg ^ rise_reg;
    end
  end

  assign sw         = sw_reg;
  assign sw_rise    = rise_reg;
  assign sw_fall    = fall_reg;
  assign sw_toggle  = toggle_reg;
  assign any_change = |(rise_reg | fall_reg);

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of independent switch/button inputs (1..32).
REQ-002 SHALL have parameter DEBOUNCE_COUNT, default 1250000 (10 ms at 125 MHz), stable cycles required to accept a new level (>= 2).
REQ-003 SHALL have parameter USEIOFF, default 1: 1 = first input stage carries syn_useioff = 1 (I/O register); 0 = fabric register with syn_useioff = 0; both variants keep syn_preserve = 1.
REQ-004 SHALL have port clk_125mhz, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-006 SHALL have port sw_n, input, WIDTH, raw asynchronous switch/button pins, active-low (0 = pressed/on).
REQ-007 SHALL have port sw, output, WIDTH, debounced level, active-high (1 = pressed/on).
REQ-008 SHALL have port sw_rise, output, WIDTH, one-cycle pulse per bit when sw goes 0->1.
REQ-009 SHALL have port sw_fall, output, WIDTH, one-cycle pulse per bit when sw goes 1->0.
REQ-010 SHALL have port sw_toggle, output, WIDTH, per-bit register inverting on each sw_rise.
REQ-011 SHALL have port any_change, output, 1, OR of all bits of sw_rise and sw_fall, in the same cycle.

Function
REQ-012 SHALL sample sw_n through three registers per bit: the I/O-stage register (REQ-003), then a two-flop synchronizer; lvl = inverted synchronizer output.
REQ-013 SHALL keep one counter per bit, $clog2(DEBOUNCE_COUNT) bits wide, never exceeding DEBOUNCE_COUNT-1.
REQ-014 SHALL, per bit per cycle: if lvl == sw, clear the counter to 0.
REQ-015 SHALL, per bit per cycle: if lvl != sw and counter < DEBOUNCE_COUNT-1, increment the counter.
REQ-016 SHALL, per bit per cycle: if lvl != sw and counter == DEBOUNCE_COUNT-1, load sw <= lvl, clear the counter, and assert sw_rise or sw_fall for exactly that same cycle.
REQ-017 SHALL give a steady sw_n edge a latency of exactly 3 + DEBOUNCE_COUNT clock cycles to the sw change.
REQ-018 SHALL discard any lvl glitch shorter than DEBOUNCE_COUNT cycles: counter restarts at 0, sw unchanged, no pulse.
REQ-019 SHALL never assert sw_rise and sw_fall together on the same bit; bits are fully independent, and simultaneous events on several bits each pulse in the same cycle.
REQ-020 SHALL register sw_toggle so it changes in the cycle after the sw_rise pulse; sw_fall has no effect on it.
REQ-021 SHALL drive every output from a register except any_change (combinational OR of registered pulses).

Reset
REQ-022 SHALL, when rst_n = 0 at a clock edge, set: I/O-stage and synchronizer flops to all-ones (released); counters 0; sw, sw_rise, sw_fall, sw_toggle, any_change 0.
REQ-023 SHALL abandon in-progress debounces when reset is asserted mid-count; no pulse is generated from a pre-reset count.
REQ-024 SHALL treat a bit held pressed through reset release as a fresh edge: sw_rise fires 3 + DEBOUNCE_COUNT cycles after the first cycle with rst_n = 1.

Verification (DEBOUNCE_COUNT = 4, WIDTH = 8)
REQ-025 SHALL cover this scenario: sw_n 8'hFF -> 8'hFE held, stimulus at cycle 0 -> sw = 8'h01 at cycle 7; sw_rise = 8'h01 and any_change = 1 for one cycle; sw_toggle[0] = 1 at cycle 8.
REQ-026 SHALL cover this scenario: sw_n[0] low for 3 cycles, then high -> sw, sw_rise, sw_fall, and any_change remain 0 throughout.
REQ-027 SHALL cover this scenario: from sw = 8'h01, release sw_n[0] -> sw = 8'h00 seven cycles later; sw_fall = 8'h01 for one cycle; sw_toggle unchanged.
REQ-028 SHALL cover this scenario: sw_n 8'hFF -> 8'h5A in one cycle -> sw = 8'hA5 and sw_rise = 8'hA5 in the same cycle (cycle 7); a single any_change pulse.
REQ-029 SHALL cover this scenario: sw_n[3] low, rst_n = 0 for 1 cycle when the counter = 2 -> no pulse from the aborted count; sw_rise[3] pulses 7 cycles after reset release.
REQ-030 SHALL cover this scenario: sw_n[1] pressed and released 3 times (each level held 10 cycles) -> 3 sw_rise pulses, 3 sw_fall pulses, sw_toggle[1] = 1 at the end.
